// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the two-port memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic PORT_FETCH = 1'b0;
    localparam logic PORT_LSU   = 1'b1;

    // Wide enough to hold RD_LAT-1 for the largest supported latency (3)
    localparam int LAT_CNT_W = 2;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin pick with a registered last-winner pointer.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       Clk1,
    input  logic       Reset_n,
    input  logic [1:0] i_req,
    input  logic       i_upd_en,
    input  logic       i_upd_id,
    output logic       o_win_id,
    output logic       o_any_req
);

    logic r_last;

    always_comb begin
        o_any_req = |i_req;
        if (&i_req) begin
            o_win_id = ~r_last;
        end else begin
            o_win_id = i_req[1];
        end
    end

    // Out of reset port 1 counts as last winner so port 0 takes the first conflict
    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_last <= PORT_LSU;
        end else if (i_upd_en) begin
            r_last <= i_upd_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin arbiter sharing single-ported memory between fetch and LSU.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 16,
    parameter int RD_LAT = 1
)
(
    input  logic          Clk1,
    input  logic          Reset_n,
    input  logic          P0Req,
    input  logic          P0We,
    input  logic [AW-1:0] P0Addr,
    input  logic [DW-1:0] P0WData,
    output logic          P0Gnt,
    output logic          P0RValid,
    output logic [DW-1:0] P0RData,
    input  logic          P1Req,
    input  logic          P1We,
    input  logic [AW-1:0] P1Addr,
    input  logic [DW-1:0] P1WData,
    output logic          P1Gnt,
    output logic          P1RValid,
    output logic [DW-1:0] P1RData,
    output logic [AW-1:0] MemAddr,
    output logic          MemRD,
    output logic          MemWR,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData,
    output logic          Busy
);

    state_t               r_state;
    logic                 r_port;
    logic                 r_we;
    logic [LAT_CNT_W-1:0] r_cnt;

    logic                 w_win_id;
    logic                 w_any_req;
    logic                 w_upd_en;
    logic                 w_we;
    logic [AW-1:0]        w_addr;
    logic [DW-1:0]        w_wdata;

    assign w_upd_en = (r_state == ISSUE);
    assign w_we     = w_win_id ? P1We    : P0We;
    assign w_addr   = w_win_id ? P1Addr  : P0Addr;
    assign w_wdata  = w_win_id ? P1WData : P0WData;

    rr_arbiter2 u_rr (
        .Clk1      (Clk1),
        .Reset_n   (Reset_n),
        .i_req     ({P1Req, P0Req}),
        .i_upd_en  (w_upd_en),
        .i_upd_id  (r_port),
        .o_win_id  (w_win_id),
        .o_any_req (w_any_req)
    );

    always_ff @(posedge Clk1 or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state  <= IDLE;
            r_port   <= PORT_FETCH;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            P0Gnt    <= 1'b0;
            P1Gnt    <= 1'b0;
            P0RValid <= 1'b0;
            P1RValid <= 1'b0;
            P0RData  <= '0;
            P1RData  <= '0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemRD    <= 1'b0;
            MemWR    <= 1'b0;
            Busy     <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses; MemAddr/MemWData/RData hold
            P0Gnt    <= 1'b0;
            P1Gnt    <= 1'b0;
            P0RValid <= 1'b0;
            P1RValid <= 1'b0;
            MemRD    <= 1'b0;
            MemWR    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_port   <= w_win_id;
                        r_we     <= w_we;
                        MemAddr  <= w_addr;
                        MemWData <= w_wdata;
                        MemRD    <= ~w_we;
                        MemWR    <= w_we;
                        P0Gnt    <= (w_win_id == PORT_FETCH);
                        P1Gnt    <= (w_win_id == PORT_LSU);
                        Busy     <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (r_we) begin
                        Busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= LAT_CNT_W'(RD_LAT - 1);
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        if (r_port == PORT_LSU) begin
                            P1RData  <= MemRData;
                            P1RValid <= 1'b1;
                        end else begin
                            P0RData  <= MemRData;
                            P0RValid <= 1'b1;
                        end
                        r_state <= RESP;
                    end else begin
                        r_cnt <= r_cnt - LAT_CNT_W'(1);
                    end
                end
                RESP: begin
                    Busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int RD_LAT = 2;
    localparam int NMAX   = 8192;

    logic          Clk1 = 1'b0;
    logic          Reset_n;
    logic          P0Req, P0We, P1Req, P1We;
    logic [AW-1:0] P0Addr, P1Addr;
    logic [DW-1:0] P0WData, P1WData;
    logic          P0Gnt, P0RValid, P1Gnt, P1RValid;
    logic [DW-1:0] P0RData, P1RData;
    logic [AW-1:0] MemAddr;
    logic          MemRD, MemWR, Busy;
    logic [DW-1:0] MemWData, MemRData;

    always #5 Clk1 = ~Clk1;

    mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .Clk1     (Clk1),
        .Reset_n  (Reset_n),
        .P0Req    (P0Req),
        .P0We     (P0We),
        .P0Addr   (P0Addr),
        .P0WData  (P0WData),
        .P0Gnt    (P0Gnt),
        .P0RValid (P0RValid),
        .P0RData  (P0RData),
        .P1Req    (P1Req),
        .P1We     (P1We),
        .P1Addr   (P1Addr),
        .P1WData  (P1WData),
        .P1Gnt    (P1Gnt),
        .P1RValid (P1RValid),
        .P1RData  (P1RData),
        .MemAddr  (MemAddr),
        .MemRD    (MemRD),
        .MemWR    (MemWR),
        .MemWData (MemWData),
        .MemRData (MemRData),
        .Busy     (Busy)
    );

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    // Memory model: data for a read in cycle c appears RD_LAT cycles later
    logic [15:0] mem_arr [65536];
    bit          mem_ok  [65536];
    logic [15:0] pipe    [RD_LAT];

    always @(posedge Clk1) begin
        if (MemWR) begin
            mem_arr[MemAddr] <= MemWData;
            mem_ok[MemAddr]  <= 1'b1;
        end
        if (MemRD) begin
            pipe[0] <= mem_ok[MemAddr] ? mem_arr[MemAddr] : init_val(MemAddr);
        end else begin
            pipe[0] <= 16'($urandom);
        end
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign MemRData = pipe[RD_LAT-1];

    // Reference model: per-cycle schedule of expected events
    bit          iss_v  [NMAX];
    bit          iss_p  [NMAX];
    bit          iss_we [NMAX];
    logic [15:0] iss_a  [NMAX];
    logic [15:0] iss_d  [NMAX];
    bit          rv_v   [NMAX];
    bit          rv_p   [NMAX];
    logic [15:0] rv_d   [NMAX];
    bit          busy_e [NMAX];
    logic [15:0] ref_mem [65536];
    bit          ref_ok  [65536];
    int          cyc;
    int          free_at;
    bit          last_win;
    logic [15:0] run_a, run_d, run_r0, run_r1;
    int          n_cmp;
    int          n_err;

    function automatic logic [70:0] act_vec();
        return {P0Gnt, P1Gnt, P0RValid, P1RValid, MemRD, MemWR, Busy,
                MemAddr, MemWData, P0RData, P1RData};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic clear_from(input int k);
        for (int m = k; m < NMAX; m++) begin
            iss_v[m]  = 1'b0;
            rv_v[m]   = 1'b0;
            busy_e[m] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit          w;
        bit          we;
        logic [15:0] a, d;
        if (!Reset_n) begin
            clear_from(cyc + 1);
            last_win = 1'b1;
            free_at  = cyc + 1;
            run_a = '0; run_d = '0; run_r0 = '0; run_r1 = '0;
        end else if (cyc >= free_at && (P0Req || P1Req) && cyc + 3 + RD_LAT < NMAX) begin
            w  = (P0Req && P1Req) ? ~last_win : P1Req;
            last_win = w;
            we = w ? P1We    : P0We;
            a  = w ? P1Addr  : P0Addr;
            d  = w ? P1WData : P0WData;
            iss_v[cyc+1]  = 1'b1;
            iss_p[cyc+1]  = w;
            iss_we[cyc+1] = we;
            iss_a[cyc+1]  = a;
            iss_d[cyc+1]  = d;
            busy_e[cyc+1] = 1'b1;
            if (we) begin
                ref_mem[a] = d;
                ref_ok[a]  = 1'b1;
                free_at    = cyc + 2;
            end else begin
                rv_v[cyc+2+RD_LAT] = 1'b1;
                rv_p[cyc+2+RD_LAT] = w;
                rv_d[cyc+2+RD_LAT] = ref_ok[a] ? ref_mem[a] : init_val(a);
                for (int k = cyc + 2; k <= cyc + 2 + RD_LAT; k++) busy_e[k] = 1'b1;
                free_at = cyc + 3 + RD_LAT;
            end
        end
    endtask

    task automatic compare_cycle();
        logic [70:0] exp;
        if (iss_v[cyc]) begin
            run_a = iss_a[cyc];
            run_d = iss_d[cyc];
        end
        if (rv_v[cyc]) begin
            if (rv_p[cyc]) run_r1 = rv_d[cyc];
            else           run_r0 = rv_d[cyc];
        end
        exp = {iss_v[cyc] && !iss_p[cyc], iss_v[cyc] && iss_p[cyc],
               rv_v[cyc] && !rv_p[cyc], rv_v[cyc] && rv_p[cyc],
               iss_v[cyc] && !iss_we[cyc], iss_v[cyc] && iss_we[cyc], busy_e[cyc],
               run_a, run_d, run_r0, run_r1};
        chk("cycle_outputs", {57'd0, act_vec()}, {57'd0, exp});
    endtask

    task automatic tick();
        model_step();
        @(posedge Clk1);
        #1;
        cyc++;
        if (cyc < NMAX) compare_cycle();
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 16'hFFFF;
        return 16'($urandom_range(0, 15));
    endfunction

    initial begin
        int ng;
        n_cmp = 0; n_err = 0; cyc = 0; free_at = 0; last_win = 1'b1;
        run_a = '0; run_d = '0; run_r0 = '0; run_r1 = '0;
        clear_from(0);
        Reset_n = 1'b0;
        P0Req = 0; P0We = 0; P0Addr = '0; P0WData = '0;
        P1Req = 0; P1We = 0; P1Addr = '0; P1WData = '0;

        repeat (3) tick();
        chk("reset_outputs", {57'd0, act_vec()}, 128'd0);
        Reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_no_strobe", {125'd0, MemRD, MemWR, Busy}, 128'd0);

        // Port 0 write 0xBEEF to 0x0010
        P0Req = 1; P0We = 1; P0Addr = 16'h0010; P0WData = 16'hBEEF;
        tick();
        chk("wr_strobe_gnt", {124'd0, MemWR, MemRD, P0Gnt, P1Gnt}, {124'd0, 4'b1010});
        chk("wr_addr_data", {96'd0, MemAddr, MemWData}, {96'd0, 16'h0010, 16'hBEEF});
        P0Req = 0;
        tick();
        chk("wr_busy_low", {127'd0, Busy}, 128'd0);

        // Port 1 read 0x0010
        P1Req = 1; P1We = 0; P1Addr = 16'h0010;
        tick();
        chk("rd_strobe", {109'd0, MemRD, MemWR, P1Gnt, MemAddr}, {109'd0, 3'b101, 16'h0010});
        P1Req = 0;
        repeat (3) tick();
        chk("rd_resp", {110'd0, P1RValid, P0RValid, P1RData}, {110'd0, 2'b10, 16'hBEEF});
        tick();

        // Port 1 read of the top address
        P1Req = 1; P1We = 0; P1Addr = 16'hFFFF;
        tick();
        chk("ffff_strobe", {111'd0, MemRD, MemAddr}, {111'd0, 1'b1, 16'hFFFF});
        P1Req = 0;
        repeat (3) tick();
        chk("ffff_resp", {111'd0, P1RValid, P1RData}, {111'd0, 1'b1, 16'hA5A5});
        tick();

        // Both ports reading continuously from reset
        Reset_n = 1'b0;
        repeat (3) tick();
        Reset_n = 1'b1;
        P0Req = 1; P0We = 0; P0Addr = 16'h0020;
        P1Req = 1; P1We = 0; P1Addr = 16'h0030;
        ng = 0;
        for (int i = 0; i < 60 && ng < 4; i++) begin
            tick();
            if (P0Gnt || P1Gnt) begin
                chk("alt_grant", {126'd0, P0Gnt, P1Gnt},
                    (ng % 2 == 0) ? 128'd2 : 128'd1);
                ng++;
            end
        end
        chk("alt_grant_count", 128'(ng), 128'd4);
        P0Req = 0; P1Req = 0;
        repeat (8) tick();

        // Reset during WAIT of a port 0 read
        P0Req = 1; P0We = 0; P0Addr = 16'h0040;
        tick();
        chk("abort_gnt", {127'd0, P0Gnt}, 128'd1);
        P0Req = 0;
        tick();
        Reset_n = 1'b0;
        #1;
        chk("reset_async_clear", {57'd0, act_vec()}, 128'd0);
        repeat (2) begin
            tick();
            chk("abort_no_rvalid", {127'd0, P0RValid}, 128'd0);
        end
        Reset_n = 1'b1;
        P0Req = 1; P0We = 0; P0Addr = 16'h0050;
        P1Req = 1; P1We = 0; P1Addr = 16'h0060;
        tick();
        chk("post_reset_winner", {126'd0, P0Gnt, P1Gnt}, 128'd2);

        // Randomized traffic; requests held until granted
        for (int i = 0; i < 3000; i++) begin
            if (P0Req && P0Gnt) P0Req = 0;
            if (P1Req && P1Gnt) P1Req = 0;
            if (!P0Req && $urandom_range(0, 2) == 0) begin
                P0Req = 1; P0We = 1'($urandom_range(0, 1));
                P0Addr = rand_addr(); P0WData = 16'($urandom);
            end
            if (!P1Req && $urandom_range(0, 2) == 0) begin
                P1Req = 1; P1We = 1'($urandom_range(0, 1));
                P1Addr = rand_addr(); P1WData = 16'($urandom);
            end
            tick();
        end
        P0Req = 0; P1Req = 0;
        repeat (10) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
